stopwatch_ctrl: RTL and testbench

//  Run-control stage directly upstream of the two-digit BCD 00-99 counter and display driver.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_btn_debounce.sv | 55 +++++
 rtl/stopwatch_ctrl.sv | 110 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control stage and the BCD counter top level.
//   sw_state_t          : run-control FSM state encoding
//   TICK_DIV_DEFAULT    : clocks per count_en pulse (1 Hz at 50 MHz)
//   DEB_CYCLES_DEFAULT  : stable cycles needed before a button level change is accepted
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned TICK_DIV_DEFAULT   = 50_000_000;
    localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter, rising-edge press pulse.
//   clock    in  system clock
//   reset    in  asynchronous, active-high
//   btn_raw  in  raw bouncy button level, asynchronous to clock
//   press_c  out one-cycle pulse on an accepted rising edge of the debounced level
//                (combinational from registered state)
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press_c
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] deb_cnt;

    // Synchroniser, debounce counter and debounced level history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_q <= stable;
            if (sync2 != stable) begin
                // Accept the new level on the edge the count would reach DEB_CYCLES
                if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                    stable  <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Rising edge only; a release produces nothing
    assign press_c = stable & ~stable_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: turns start/stop and clear buttons into count enables and
// clear requests for the downstream two-digit BCD counter.
//   clock          in   system clock
//   reset          in   asynchronous, active-high
//   btn_start_raw  in   start/stop button, raw and bouncy
//   btn_clear_raw  in   clear button, raw and bouncy
//   count_en       out  one-cycle pulse per TICK_DIV clocks spent in RUN
//   clear_req      out  one-cycle pulse after a clear press
//   running        out  high while in RUN
//   pre_cnt        out  prescaler value
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        btn_start_raw,
    input  logic                        btn_clear_raw,
    output logic                        count_en,
    output logic                        clear_req,
    output logic                        running,
    output logic [$clog2(TICK_DIV)-1:0] pre_cnt
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic      ss_press_c;
    logic      clr_press_c;
    sw_state_t state;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_start_raw),
        .press_c (ss_press_c)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_clear_raw),
        .press_c (clr_press_c)
    );

    // FSM, prescaler and registered outputs; clear always takes priority over start/stop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            count_en  <= 1'b0;
            clear_req <= 1'b0;
            running   <= 1'b0;
        end else begin
            count_en  <= 1'b0;
            clear_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pre_cnt <= '0;
                    if (clr_press_c) begin
                        clear_req <= 1'b1;
                        running   <= 1'b0;
                    end else if (ss_press_c) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_press_c) begin
                        state     <= ST_IDLE;
                        clear_req <= 1'b1;
                        running   <= 1'b0;
                        pre_cnt   <= '0;
                    end else begin
                        if (ss_press_c) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                        // Prescaler advances on every RUN cycle, including the pausing one
                        if (pre_cnt == PW'(TICK_DIV - 1)) begin
                            pre_cnt  <= '0;
                            count_en <= 1'b1;
                        end else begin
                            pre_cnt <= pre_cnt + PW'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    // Prescaler holds so a resume completes the partial period
                    if (clr_press_c) begin
                        state     <= ST_IDLE;
                        clear_req <= 1'b1;
                        running   <= 1'b0;
                        pre_cnt   <= '0;
                    end else if (ss_press_c) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    pre_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYCLES=4.
// Stimulus pushes expected output events (with the cycle they must appear) and level
// checkpoints; a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned DEB      = 4;

    localparam int EV_CE   = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_RISE = 2;
    localparam int EV_FALL = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        string      name;
        int         cyc;
        logic [6:0] lv;    // {running, count_en, clear_req, pre_cnt}
    } chk_t;

    logic       clock;
    logic       reset;
    logic       btn_start_raw;
    logic       btn_clear_raw;
    logic       count_en;
    logic       clear_req;
    logic       running;
    logic [3:0] pre_cnt;

    ev_t  ev_q[$];
    chk_t chk_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;
    logic prev_running = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_start_raw (btn_start_raw),
        .btn_clear_raw (btn_clear_raw),
        .count_en      (count_en),
        .clear_req     (clear_req),
        .running       (running),
        .pre_cnt       (pre_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_CE:   return "count_en";
            EV_CLR:  return "clear_req";
            EV_RISE: return "running_rise";
            default: return "running_fall";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        ev_q.push_back(e);
    endtask

    task automatic push_chk(input string nm, input int c, input logic run,
                            input logic ce, input logic clr, input logic [3:0] pre);
        chk_t k;
        k.name = nm;
        k.cyc  = c;
        k.lv   = {run, ce, clr, pre};
        chk_q.push_back(k);
    endtask

    // Advance to just after the active edge that brings cyc to target
    task automatic wait_until(input int target);
        if (target > cyc) repeat (target - cyc) @(posedge clock);
        #1;
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        tests++;
        if (ev_q.size() == 0) begin
            fails++;
            $display("FAIL ev_unexpected: got %s at cycle %0d, want no event", kname(kind), cyc);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                fails++;
                $display("FAIL ev_order: got %s@%0d, want %s@%0d",
                         kname(kind), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: events in fixed order count_en, clear_req, running rise, running fall
    always @(negedge clock) begin
        chk_t k;
        logic [6:0] act;
        if (count_en === 1'b1) check_event(EV_CE);
        if (clear_req === 1'b1) check_event(EV_CLR);
        if (running === 1'b1 && prev_running === 1'b0) check_event(EV_RISE);
        if (running !== 1'b1 && prev_running === 1'b1) check_event(EV_FALL);
        prev_running = running;

        act = {running, count_en, clear_req, pre_cnt};
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            k = chk_q.pop_front();
            tests++;
            if (k.cyc != cyc || act !== k.lv) begin
                fails++;
                $display("FAIL chk %s cyc=%0d: got run/ce/clr/pre=%b/%b/%b/%0d, want %b/%b/%b/%0d at cyc %0d",
                         k.name, cyc, act[6], act[5], act[4], act[3:0],
                         k.lv[6], k.lv[5], k.lv[4], k.lv[3:0], k.cyc);
            end
        end

        if (end_req && !end_done) begin
            tests++;
            if (ev_q.size() != 0 || chk_q.size() != 0) begin
                fails++;
                $display("FAIL queues_drained: got %0d events and %0d checkpoints pending, want 0",
                         ev_q.size(), chk_q.size());
            end
            end_done = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c, r, p, q, u, v;
        reset         = 1'b1;
        btn_start_raw = 1'b0;
        btn_clear_raw = 1'b0;
        push_chk("reset_state", 2, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_until(3);
        reset = 1'b0;

        // Bouncy start button, then a clean hold
        for (int i = 0; i < 20; i++) begin
            btn_start_raw = ~btn_start_raw;
            wait_until(cyc + 2);
        end
        btn_start_raw = 1'b1;
        c = cyc;
        r = c + 7;
        push_ev(EV_RISE, r);
        push_ev(EV_CE, r + 10);
        push_chk("run_pre2", r + 12, 1'b1, 1'b0, 1'b0, 4'd2);
        push_ev(EV_CE, r + 20);
        push_ev(EV_FALL, r + 25);
        push_chk("pause_pre5", r + 25, 1'b0, 1'b0, 1'b0, 4'd5);
        wait_until(r);
        btn_start_raw = 1'b0;

        // Pause after 25 RUN cycles
        wait_until(r + 18);
        btn_start_raw = 1'b1;
        wait_until(r + 30);
        btn_start_raw = 1'b0;
        push_chk("pause_hold", r + 60, 1'b0, 1'b0, 1'b0, 4'd5);

        // Resume: partial period completes 5 cycles later
        p = r + 75;
        q = p + 7;
        wait_until(p);
        btn_start_raw = 1'b1;
        push_ev(EV_RISE, q);
        push_chk("resume_pre7", q + 2, 1'b1, 1'b0, 1'b0, 4'd7);
        push_ev(EV_CE, q + 5);
        wait_until(q + 1);
        btn_start_raw = 1'b0;

        // Both buttons together while prescaler is at TICK_DIV-1: clear wins, no count_en
        wait_until(q + 8);
        btn_start_raw = 1'b1;
        btn_clear_raw = 1'b1;
        push_ev(EV_CLR, q + 15);
        push_ev(EV_FALL, q + 15);
        push_chk("both_clear", q + 15, 1'b0, 1'b0, 1'b1, 4'd0);
        push_chk("both_after", q + 16, 1'b0, 1'b0, 1'b0, 4'd0);
        push_chk("both_idle", q + 60, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_until(q + 120);
        btn_start_raw = 1'b0;
        btn_clear_raw = 1'b0;

        // Clear in IDLE, held for 100 cycles
        wait_until(q + 130);
        btn_clear_raw = 1'b1;
        push_ev(EV_CLR, q + 137);
        push_chk("idle_clear_after", q + 138, 1'b0, 1'b0, 1'b0, 4'd0);
        push_chk("idle_clear_hold", q + 200, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_until(q + 237);
        btn_clear_raw = 1'b0;

        // Start held across an asynchronous mid-run reset
        u = q + 250;
        wait_until(u);
        btn_start_raw = 1'b1;
        push_ev(EV_RISE, u + 7);
        push_chk("run3_pre2", u + 9, 1'b1, 1'b0, 1'b0, 4'd2);
        wait_until(u + 10);
        #2;
        reset = 1'b1;
        push_ev(EV_FALL, u + 10);
        push_chk("async_reset", u + 10, 1'b0, 1'b0, 1'b0, 4'd0);
        push_chk("reset_hold", u + 12, 1'b0, 1'b0, 1'b0, 4'd0);
        v = u + 13;
        wait_until(v);
        reset = 1'b0;
        push_ev(EV_RISE, v + 7);
        push_chk("post_reset_pre1", v + 8, 1'b1, 1'b0, 1'b0, 4'd1);
        push_ev(EV_CE, v + 17);
        wait_until(v + 22);

        end_req = 1'b1;
        repeat (3) @(posedge clock);
        if (!end_done) begin
            $display("FAIL end_check: got monitor not finished, want finished");
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
